// File: rtl/qm_pipe_seq.sv
// Time-multiplexed Hamilton quaternion multiplier on LANES sequential radix-4 Booth engines.
// Optional output clamping to the signed 2W-bit range with per-component sat flags: QM_PIPE_SAT_EN.
module qm_pipe_seq #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 4,
  localparam int unsigned QW   = 2*W+2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          conj_b,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  a1,
  input  logic [W-1:0]  a2,
  input  logic [W-1:0]  a3,
  input  logic [W-1:0]  b0,
  input  logic [W-1:0]  b1,
  input  logic [W-1:0]  b2,
  input  logic [W-1:0]  b3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] q0,
  output logic [QW-1:0] q1,
  output logic [QW-1:0] q2,
  output logic [QW-1:0] q3,
  output logic          busy
`ifdef QM_PIPE_SAT_EN
  ,
  output logic [3:0]    sat
`endif
);

  localparam int unsigned R     = 16 / LANES;
  localparam int unsigned RW    = 4;
  localparam int unsigned STEPS = W / 2;
  localparam int unsigned CW    = $clog2(STEPS) + 1;
  localparam int unsigned PW    = W + 2;
  localparam int unsigned SW    = 2*W + 3;

`ifdef QM_PIPE_SAT_EN
  localparam logic signed [QW-1:0] SMAX = {3'b000, {(2*W-1){1'b1}}};
  localparam logic signed [QW-1:0] SMIN = {3'b111, {(2*W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_t;

  state_t state_q, state_d;

  logic [W-1:0]         a_q [4];
  logic [W-1:0]         b_q [4];
  logic                 conj_q;
  logic [RW-1:0]        rnd_q;
  logic [CW-1:0]        step_q;
  logic signed [QW-1:0] acc_q [4];

  logic signed [PW-1:0] p_q  [LANES];
  logic [W-1:0]         m_q  [LANES];
  logic [W-1:0]         y_q  [LANES];
  logic                 yp_q [LANES];

  logic [3:0]           k_c    [LANES];
  logic signed [PW-1:0] mx_c   [LANES];
  logic signed [PW-1:0] add_c  [LANES];
  logic signed [SW-1:0] shf_c  [LANES];
  logic signed [QW-1:0] prod_c [LANES];
  logic signed [QW-1:0] acc_d  [4];
  logic signed [QW-1:0] res_c  [4];
`ifdef QM_PIPE_SAT_EN
  logic [3:0]           sat_c;
`endif

  // Product index handled by lane l in round r.
  function automatic logic [3:0] lane_k(input logic [RW-1:0] r, input int l);
    int kv;
    kv = int'(r) * int'(LANES) + l;
    return 4'(kv);
  endfunction

  // Terms a_i*b_j that enter their component with a minus sign (before conjugation).
  function automatic logic term_neg(input logic [3:0] k);
    case (k)
      4'd5, 4'd7, 4'd9, 4'd10, 4'd14, 4'd15: term_neg = 1'b1;
      default:                               term_neg = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    state_d = MUL;
      MUL:     if (step_q == CW'(STEPS-1)) state_d = ACC;
      ACC:     state_d = (rnd_q == RW'(R-1)) ? DONE : LOAD;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Booth step per lane and signed routing of lane products into the four accumulators.
  always_comb begin
    for (int d = 0; d < 4; d++) acc_d[d] = acc_q[d];
    for (int l = 0; l < int'(LANES); l++) begin
      k_c[l]  = lane_k(rnd_q, l);
      mx_c[l] = PW'($signed(m_q[l]));
      case ({y_q[l][1:0], yp_q[l]})
        3'b001, 3'b010: add_c[l] = mx_c[l];
        3'b011:         add_c[l] = mx_c[l] <<< 1;
        3'b100:         add_c[l] = -(mx_c[l] <<< 1);
        3'b101, 3'b110: add_c[l] = -mx_c[l];
        default:        add_c[l] = '0;
      endcase
      shf_c[l]  = $signed({p_q[l] + add_c[l], y_q[l], yp_q[l]}) >>> 2;
      prod_c[l] = QW'($signed({p_q[l][W-1:0], y_q[l]}));
      // conj(b) flips the sign of the term rather than negating b itself
      if (term_neg(k_c[l]) ^ (conj_q && (k_c[l][1:0] != 2'd0)))
        acc_d[k_c[l][3:2] ^ k_c[l][1:0]] = acc_d[k_c[l][3:2] ^ k_c[l][1:0]] - prod_c[l];
      else
        acc_d[k_c[l][3:2] ^ k_c[l][1:0]] = acc_d[k_c[l][3:2] ^ k_c[l][1:0]] + prod_c[l];
    end
  end

  always_comb begin
`ifdef QM_PIPE_SAT_EN
    sat_c = '0;
    for (int d = 0; d < 4; d++) begin
      res_c[d] = acc_d[d];
      if (acc_d[d] > SMAX) begin
        res_c[d] = SMAX;
        sat_c[d] = 1'b1;
      end else if (acc_d[d] < SMIN) begin
        res_c[d] = SMIN;
        sat_c[d] = 1'b1;
      end
    end
`else
    for (int d = 0; d < 4; d++) res_c[d] = acc_d[d];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      q0        <= '0;
      q1        <= '0;
      q2        <= '0;
      q3        <= '0;
`ifdef QM_PIPE_SAT_EN
      sat       <= '0;
`endif
      conj_q    <= 1'b0;
      rnd_q     <= '0;
      step_q    <= '0;
      for (int d = 0; d < 4; d++) begin
        a_q[d]   <= '0;
        b_q[d]   <= '0;
        acc_q[d] <= '0;
      end
      for (int l = 0; l < int'(LANES); l++) begin
        p_q[l]  <= '0;
        m_q[l]  <= '0;
        y_q[l]  <= '0;
        yp_q[l] <= 1'b0;
      end
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      case (state_q)
        IDLE: if (in_valid) begin
          a_q[0] <= a0;  a_q[1] <= a1;  a_q[2] <= a2;  a_q[3] <= a3;
          b_q[0] <= b0;  b_q[1] <= b1;  b_q[2] <= b2;  b_q[3] <= b3;
          conj_q <= conj_b;
          rnd_q  <= '0;
          for (int d = 0; d < 4; d++) acc_q[d] <= '0;
        end
        LOAD: begin
          step_q <= '0;
          for (int l = 0; l < int'(LANES); l++) begin
            m_q[l]  <= a_q[k_c[l][3:2]];
            y_q[l]  <= b_q[k_c[l][1:0]];
            yp_q[l] <= 1'b0;
            p_q[l]  <= '0;
          end
        end
        MUL: begin
          step_q <= step_q + CW'(1);
          for (int l = 0; l < int'(LANES); l++) begin
            p_q[l]  <= shf_c[l][SW-1:W+1];
            y_q[l]  <= shf_c[l][W:1];
            yp_q[l] <= shf_c[l][0];
          end
        end
        ACC: begin
          for (int d = 0; d < 4; d++) acc_q[d] <= acc_d[d];
          if (rnd_q == RW'(R-1)) begin
            q0 <= res_c[0];
            q1 <= res_c[1];
            q2 <= res_c[2];
            q3 <= res_c[3];
`ifdef QM_PIPE_SAT_EN
            sat <= sat_c;
`endif
          end else begin
            rnd_q <= rnd_q + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
